// File: rtl/regc_arb_pkg.sv
// regc_arb_pkg: shared types and constants for the register C write arbiter
package regc_arb_pkg;
    typedef enum logic {IDLE, OWNED} state_t;
    localparam int DATA_W = 32;
    localparam int IDX_W = 2;
    localparam int LOCK_MAX_DEF = 4;
    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] i, input int n);
        return (int'(i) >= n - 1) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first valid at or after ptr (mod NREQ)
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW = 2
)(
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    always_comb begin
        int c;
        grant = '0;
        idx = '0;
        any = 1'b0;
        c = 0;
        // Scan from the farthest candidate down so the one nearest ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            c = (c >= NREQ) ? c - NREQ : c;
            if (valid[c]) begin
                grant = '0;
                grant[c] = 1'b1;
                idx = IW'(c);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regc_write_arbiter.sv
// regc_write_arbiter: round-robin arbiter sharing register C among producers, with locked bursts
module regc_write_arbiter
    import regc_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW = DATA_W,
    parameter int LOCK_MAX = LOCK_MAX_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_c,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              load_c,
    output logic [DW-1:0]     data_c,
    output logic [IDX_W-1:0]  grant_id
);
    localparam int BW = $clog2(LOCK_MAX + 1);

    state_t state, stateNext;
    logic [IDX_W-1:0] ptr, ptrNext, owner, ownerNext, winIdx;
    logic [BW-1:0] beats, beatsNext;
    logic [NREQ-1:0] ownerMask, pickValid, pickGrant;
    logic pickAny, accept, lastBeat;

    // While a burst is locked only the owner is offered to the picker.
    assign ownerMask = NREQ'(1) << owner;
    assign pickValid = (state == OWNED) ? (req_valid & ownerMask) : req_valid;
    assign lastBeat = int'(beats) + 1 >= LOCK_MAX;

    rr_pick #(.NREQ(NREQ), .IW(IDX_W)) picker (
        .valid(pickValid),
        .ptr(ptr),
        .grant(pickGrant),
        .idx(winIdx),
        .any(pickAny)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            beats <= '0;
        end else begin
            state <= stateNext;
            ptr <= ptrNext;
            owner <= ownerNext;
            beats <= beatsNext;
        end
    end

    // Any non-locking accept, or an owner that stops presenting, ends ownership.
    always_comb begin
        stateNext = state;
        ptrNext = ptr;
        ownerNext = owner;
        beatsNext = beats;
        if (accept && req_lock[winIdx] && !lastBeat) begin
            stateNext = OWNED;
            ownerNext = winIdx;
            beatsNext = beats + 1'b1;
        end else if (accept || (state == OWNED && !hold_c)) begin
            stateNext = IDLE;
            ptrNext = nextIdx((state == OWNED) ? owner : winIdx, NREQ);
            beatsNext = '0;
        end
    end

    always_comb begin
        req_ready = (rst || hold_c) ? '0 : pickGrant;
        accept = !rst && !hold_c && pickAny;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_c <= 1'b0;
            data_c <= '0;
            grant_id <= '0;
        end else begin
            load_c <= accept;
            if (accept) begin
                data_c <= req_data[int'(winIdx)*DW +: DW];
                grant_id <= winIdx;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : gStable
        assert property (@(posedge clk) disable iff (rst)
            req_valid[g] && !req_ready[g] |=>
            req_valid[g] && $stable(req_lock[g]) && $stable(req_data[g*DW +: DW]));
    end
endmodule

// File: tb/tb_regc_write_arbiter.sv
// tb_regc_write_arbiter: directed self-checking bench for the register C write arbiter
module tb_regc_write_arbiter;
    import regc_arb_pkg::*;
    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic rst, hold_c;
    logic [NREQ-1:0] req_valid, req_lock, req_ready;
    logic [NREQ*DATA_W-1:0] req_data;
    logic load_c;
    logic [DATA_W-1:0] data_c;
    logic [IDX_W-1:0] grant_id;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regc_write_arbiter #(.NREQ(NREQ), .DW(DATA_W), .LOCK_MAX(4)) dut (
        .clk(clk),
        .rst(rst),
        .hold_c(hold_c),
        .req_valid(req_valid),
        .req_lock(req_lock),
        .req_data(req_data),
        .req_ready(req_ready),
        .load_c(load_c),
        .data_c(data_c),
        .grant_id(grant_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expOut(input string tag, input logic ld, input logic [31:0] d, input logic [1:0] id);
        check({tag, "_load"}, 32'(load_c), 32'(ld));
        check({tag, "_data"}, data_c, d);
        check({tag, "_id"}, 32'(grant_id), 32'(id));
    endtask

    task automatic setData(input int i, input logic [31:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic doReset(input logic [2:0] v, input logic [2:0] l);
        rst = 1'b1;
        hold_c = 1'b0;
        req_valid = v;
        req_lock = l;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        hold_c = 1'b0;
        req_valid = '1;
        req_lock = '0;
        req_data = '0;
        setData(0, 32'h11);
        setData(1, 32'h22);
        setData(2, 32'h33);
        #1 check("rst_ready0", 32'(req_ready), 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_ready", 32'(req_ready), 0);
            expOut("rst", 1'b0, 0, 2'd0);
        end
        rst = 1'b0;
        #1 check("rot_ready", 32'(req_ready), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            expOut("rot", 1'b1, 32'((k % 3 + 1) * 'h11), 2'(k % 3));
        end

        setData(1, 32'hA0);
        doReset(3'b110, 3'b010);
        expOut("bst_rst", 1'b0, 0, 2'd0);
        check("bst_ready0", 32'(req_ready), 2);
        for (int b = 0; b < 4; b++) begin
            tick();
            expOut("bst", 1'b1, 32'('hA0 + b), 2'd1);
            setData(1, 32'('hA1 + b));
            #1 check("bst_ready", 32'(req_ready), (b < 3) ? 2 : 4);
        end
        tick();
        expOut("bst_next", 1'b1, 32'h33, 2'd2);

        setData(1, 32'hB0);
        doReset(3'b110, 3'b010);
        for (int b = 0; b < 2; b++) begin
            tick();
            expOut("hld_pre", 1'b1, 32'('hB0 + b), 2'd1);
            setData(1, 32'('hB1 + b));
        end
        hold_c = 1'b1;
        #1 check("hld_ready", 32'(req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expOut("hld_frozen", 1'b0, 32'hB1, 2'd1);
            check("hld_ready_frozen", 32'(req_ready), 0);
        end
        hold_c = 1'b0;
        #1 check("hld_resume", 32'(req_ready), 2);
        for (int b = 2; b < 4; b++) begin
            tick();
            expOut("hld_post", 1'b1, 32'('hB0 + b), 2'd1);
            setData(1, 32'('hB1 + b));
        end
        #1 check("hld_exit", 32'(req_ready), 4);

        setData(0, 32'h10);
        setData(1, 32'h55);
        setData(2, 32'h30);
        doReset(3'b010, 3'b000);
        check("rmid_ready0", 32'(req_ready), 2);
        tick();
        expOut("rmid_acc", 1'b1, 32'h55, 2'd1);
        rst = 1'b1;
        #1 check("rmid_ready_rst", 32'(req_ready), 0);
        tick();
        expOut("rmid_rst", 1'b0, 0, 2'd0);
        rst = 1'b0;
        req_valid = 3'b111;
        #1 check("rmid_ready", 32'(req_ready), 1);
        tick();
        expOut("rmid_next", 1'b1, 32'h10, 2'd0);

        setData(2, 32'h77);
        doReset(3'b100, 3'b000);
        check("lone_ready0", 32'(req_ready), 4);
        for (int k = 0; k < 2; k++) begin
            tick();
            expOut("lone", 1'b1, 32'h77, 2'd2);
            #1 check("lone_ready", 32'(req_ready), 4);
        end
        req_lock = 3'b100;
        setData(2, 32'h78);
        tick();
        expOut("lone_lock", 1'b1, 32'h78, 2'd2);
        req_valid = 3'b101;
        setData(2, 32'h79);
        #1 check("own_excl", 32'(req_ready), 4);
        tick();
        expOut("own_beat", 1'b1, 32'h79, 2'd2);
        req_valid = 3'b001;
        #1 check("own_drop", 32'(req_ready), 0);
        tick();
        expOut("own_idle", 1'b0, 32'h79, 2'd2);
        #1 check("own_ptr", 32'(req_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
